// File: rtl/eq2_run_monitor.sv
// ----------------------------------------------------------------------------
// eq2_run_monitor
//
// Purpose:
//   Sits directly behind a 2-bit equality comparator (eq2). Each accepted
//   operand pair is compared (a == b). The result is forwarded through a
//   single registered output stage. The block also tracks runs of consecutive
//   matches and declares "locked" once RUN_LEN matches in a row have been seen.
//   A saturating mismatch counter is kept for status/debug readout.
//
// Parameters:
//   RUN_LEN  consecutive matches needed to lock (1 .. 2**CNT_W-1)
//   CNT_W    width of the run_len and mismatch_cnt counters
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      operand pair valid
//   in_ready      stage can accept a pair (combinational from out_ready)
//   a, b          2-bit operands
//   clear         synchronous clear of FSM and counters (not the output reg)
//   out_valid     registered result valid
//   out_ready     downstream accepts result
//   out_eq        registered (a == b) of the last accepted pair
//   locked        high while the FSM is in LOCKED
//   lock_pulse    one-cycle pulse on SEARCH -> LOCKED
//   unlock_pulse  one-cycle pulse on LOCKED -> SEARCH
//   run_len       current consecutive-match count (saturating)
//   mismatch_cnt  mismatches since reset/clear (saturating)
// ----------------------------------------------------------------------------
module eq2_run_monitor #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eq,
    output logic             locked,
    output logic             lock_pulse,
    output logic             unlock_pulse,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Counters stop at all-ones instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A match arriving while run_len equals this value completes the run.
    localparam logic [CNT_W-1:0] LOCK_AT = CNT_W'(RUN_LEN - 1);

    state_t state;
    logic   aeqb;
    logic   accept;

    // eq2 comparator: the 2-bit equality function evaluated on the current
    // operands. Its output is only sampled on an accept, so the operands are
    // don't-care (and may even be X) on any other cycle.
    assign aeqb = (a == b);

    // The single output register can take a new pair whenever it is empty or
    // is being drained this very cycle, which gives full throughput at the
    // cost of a combinational path from out_ready to in_ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // One sequential block holds the output register, the counters and the
    // SEARCH/LOCKED FSM. The pulses default low every cycle so they last
    // exactly one cycle. clear wins over a same-cycle accept for the tracking
    // state, but the accepted pair still goes to the output register, which
    // clear never touches. Leaving LOCKED through clear raises no
    // unlock_pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_eq       <= 1'b0;
            state        <= SEARCH;
            locked       <= 1'b0;
            lock_pulse   <= 1'b0;
            unlock_pulse <= 1'b0;
            run_len      <= '0;
            mismatch_cnt <= '0;
        end else begin
            lock_pulse   <= 1'b0;
            unlock_pulse <= 1'b0;

            if (accept) begin
                out_valid <= 1'b1;
                out_eq    <= aeqb;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                state        <= SEARCH;
                locked       <= 1'b0;
                run_len      <= '0;
                mismatch_cnt <= '0;
            end else if (accept) begin
                if (aeqb) begin
                    if (run_len != CNT_MAX) begin
                        run_len <= run_len + CNT_W'(1);
                    end
                    if (state == SEARCH && run_len == LOCK_AT) begin
                        state      <= LOCKED;
                        locked     <= 1'b1;
                        lock_pulse <= 1'b1;
                    end
                end else begin
                    run_len <= '0;
                    if (mismatch_cnt != CNT_MAX) begin
                        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    end
                    if (state == LOCKED) begin
                        state        <= SEARCH;
                        locked       <= 1'b0;
                        unlock_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
